// File: rtl/ps2_key_tracker_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 key tracker.
//   - PS/2 prefix bytes (extended, break, pause) and the pause skip length
//   - key event layout {make, ext, code[7:0]} as a packed struct
//   - receiver FSM state encoding
//   - scan codes used by the tank game
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam int         PAUSE_SKIP = 7;

    // Event word layout
    localparam int EVT_W        = 10;
    localparam int EVT_CODE_LSB = 0;
    localparam int EVT_EXT_BIT  = 8;
    localparam int EVT_MAKE_BIT = 9;

    typedef struct packed {
        logic       make;   // 1 = press, 0 = release
        logic       ext;    // E0-prefixed key
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_CHECK
    } rx_state_t;

    // Game keys (set 2). Arrows are E0-prefixed.
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    // Captured frame tail {stop, parity, data[7:0]}: odd parity and stop = 1.
    function automatic logic frame_ok(input logic [9:0] tail);
        return (^tail[8:0]) && tail[9];
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// ps2_key_tracker_if: key event stream from the tracker to the game controller.
//   evt_valid  FIFO head valid
//   evt_ready  consumer accepts head
//   evt_data   {make, ext, code}
//   evt_count  FIFO occupancy
// master = tracker, slave = consumer.
interface ps2_key_tracker_if #(
    parameter int FIFO_DEPTH = 8
);
    import ps2_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             evt_valid;
    logic             evt_ready;
    ps2_evt_t         evt_data;
    logic [CNT_W-1:0] evt_count;

    modport master (output evt_valid, evt_data, evt_count, input  evt_ready);
    modport slave  (input  evt_valid, evt_data, evt_count, output evt_ready);

endinterface

// File: rtl/ps2_key_tracker_frame_rx.sv
// ps2_frame_rx: PS/2 line conditioning and 11-bit frame receiver.
//   clk_100mhz, rst_n   system clock, async active-low reset
//   ps2_clk_i/ps2_data_i raw PS/2 pins
//   byte_valid_o        1-cycle strobe, byte_o holds an accepted data byte
//   byte_o              accepted data byte
//   frame_err_o         1-cycle pulse on bad start, parity/stop or watchdog abort
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);

    localparam int FW = $clog2(FILTER_LEN);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    // Synchronizers and filters; index 0 = clock line, 1 = data line.
    logic [1:0]         clk_sync_q, data_sync_q;
    logic [1:0]         raw;
    logic [1:0]         filt_q;
    logic [1:0][FW-1:0] fcnt_q;
    logic               filt_clk_prev_q;
    logic               fall;
    logic               bit_in;

    assign raw = {data_sync_q[1], clk_sync_q[1]};

    // Lines are preset high so reset looks like an idle bus.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q      <= 2'b11;
            data_sync_q     <= 2'b11;
            filt_q          <= 2'b11;
            fcnt_q          <= '0;
            filt_clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q      <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q     <= {data_sync_q[0], ps2_data_i};
            filt_clk_prev_q <= filt_q[0];
            // Filtered level flips only after FILTER_LEN consecutive differing samples.
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= raw[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign fall   = filt_clk_prev_q & ~filt_q[0];
    assign bit_in = filt_q[1];

    // Receiver FSM
    rx_state_t     state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;       // {stop, parity, data[7:0]} once full
    logic [WW-1:0] wd_q, wd_d;
    logic [7:0]    byte_q, byte_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values; the next-state logic below uses blocking (=).
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RX_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            wd_q         <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            wd_q         <= wd_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        wd_d         = wd_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            RX_IDLE: begin
                wd_d = '0;
                if (fall) begin
                    if (!bit_in) begin
                        state_d   = RX_SHIFT;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            RX_SHIFT: begin
                if (fall) begin
                    wd_d    = '0;
                    shift_d = {bit_in, shift_q[9:1]};   // LSB first
                    if (bit_cnt_q == 4'd9) begin
                        state_d = RX_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = RX_IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RX_CHECK: begin
                state_d = RX_IDLE;
                if (frame_ok(shift_q)) begin
                    byte_valid_d = 1'b1;
                    byte_d       = shift_q[7:0];
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_o       = byte_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 keyboard front end for the tank game.
//   clk_100mhz, rst_n     system clock, async active-low reset
//   ps2_clk, ps2_data     raw PS/2 pins
//   evt (master)          key event FIFO: evt_valid/evt_ready/evt_data/evt_count
//   query_code            {ext, code} to look up in the held-key bitmap
//   query_held            held state of query_code, 1-cycle latency
//   any_held              at least one key held
//   frame_err             1-cycle pulse on a discarded frame
//   fifo_ovf              1-cycle pulse when an event is dropped (FIFO full)
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int REPORT_REPEAT  = 0
) (
    input  logic               clk_100mhz,
    input  logic               rst_n,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    ps2_key_tracker_if.master  evt,
    input  logic [8:0]         query_code,
    output logic               query_held,
    output logic               any_held,
    output logic               frame_err,
    output logic               fifo_ovf
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_err;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk_100mhz   (clk_100mhz),
        .rst_n        (rst_n),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .byte_valid_o (rx_valid),
        .byte_o       (rx_byte),
        .frame_err_o  (rx_err)
    );

    // Prefix decoder: E0/F0 set flags, E1 skips the rest of the Pause sequence.
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [2:0] skip_q, skip_d;
    logic       evt_fire;
    ps2_evt_t   evt_new;

    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        skip_d   = skip_q;
        evt_fire = 1'b0;
        evt_new  = '{make: ~brk_q, ext: ext_q, code: rx_byte};
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (skip_q != '0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (rx_byte)
                    PS2_EXT:   ext_d  = 1'b1;
                    PS2_BRK:   brk_d  = 1'b1;
                    PS2_PAUSE: skip_d = 3'(PAUSE_SKIP);
                    default: begin
                        evt_fire = 1'b1;
                        ext_d    = 1'b0;
                        brk_d    = 1'b0;
                    end
                endcase
            end
        end
    end

    // Held-key bitmap indexed by {ext, code}
    logic [511:0] bitmap_q, bitmap_d;
    logic [8:0]   key_idx;
    logic         push_req;

    always_comb begin
        bitmap_d = bitmap_q;
        push_req = 1'b0;
        key_idx  = {evt_new.ext, evt_new.code};
        if (evt_fire) begin
            if (evt_new.make) begin
                // Typematic repeat of a held key only reported when enabled.
                push_req          = !bitmap_q[key_idx] || (REPORT_REPEAT != 0);
                bitmap_d[key_idx] = 1'b1;
            end else begin
                push_req          = 1'b1;
                bitmap_d[key_idx] = 1'b0;
            end
        end
    end

    // Event FIFO, first-word fall-through
    ps2_evt_t         mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             fifo_valid, full, pop, push_ok, drop;

    assign fifo_valid = (count_q != '0);
    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = fifo_valid && evt.evt_ready;
    assign push_ok    = push_req && (!full || pop);
    assign drop       = push_req && full && !pop;

    // NOTE: the storage array has no reset; count_q alone says which entries
    // are meaningful, so resetting the array would only cost flops.
    always_ff @(posedge clk_100mhz) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= evt_new;
        end
    end

    logic query_held_q, any_held_q, fifo_ovf_q;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            skip_q       <= '0;
            bitmap_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            query_held_q <= 1'b0;
            any_held_q   <= 1'b0;
            fifo_ovf_q   <= 1'b0;
        end else begin
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            skip_q       <= skip_d;
            bitmap_q     <= bitmap_d;
            query_held_q <= bitmap_q[query_code];
            any_held_q   <= |bitmap_q;
            fifo_ovf_q   <= drop;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;   // wraps at FIFO_DEPTH
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign evt.evt_valid = fifo_valid;
    assign evt.evt_data  = fifo_valid ? mem_q[rd_ptr_q] : '0;
    assign evt.evt_count = count_q;
    assign query_held    = query_held_q;
    assign any_held      = any_held_q;
    assign frame_err     = rx_err;
    assign fifo_ovf      = fifo_ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker. dut0 suppresses typematic repeats,
// dut1 reports them; both see the same PS/2 traffic.
module tb_ps2_key_tracker;
    import ps2_pkg::*;

    localparam int HALF  = 20;    // PS/2 half bit period in clk cycles
    localparam int TO    = 400;   // watchdog length for simulation
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [8:0] query_code = '0;
    logic       qh0, qh1, ah0, ah1, fe0, fe1, ov0, ov1;

    int tests = 0;
    int fails = 0;
    int ferr0 = 0, ferr1 = 0, ovf0 = 0, ovf1 = 0;

    ps2_key_tracker_if #(.FIFO_DEPTH(DEPTH)) bus0 ();
    ps2_key_tracker_if #(.FIFO_DEPTH(DEPTH)) bus1 ();

    ps2_key_tracker #(
        .FILTER_LEN(8), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .REPORT_REPEAT(0)
    ) dut0 (
        .clk_100mhz(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .evt(bus0), .query_code(query_code), .query_held(qh0), .any_held(ah0),
        .frame_err(fe0), .fifo_ovf(ov0)
    );

    ps2_key_tracker #(
        .FILTER_LEN(8), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .REPORT_REPEAT(1)
    ) dut1 (
        .clk_100mhz(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .evt(bus1), .query_code(query_code), .query_held(qh1), .any_held(ah1),
        .frame_err(fe1), .fifo_ovf(ov1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fe0) ferr0 <= ferr0 + 1;
        if (fe1) ferr1 <= ferr1 + 1;
        if (ov0) ovf0  <= ovf0 + 1;
        if (ov1) ovf1  <= ovf1 + 1;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par = 1'b0);
        send_bits(frame_bits(b, bad_par), 11);
    endtask

    task automatic pop_ev(input int which, input string tag, input logic [9:0] exp);
        int   n;
        logic v;
        n = 0;
        v = (which == 0) ? bus0.evt_valid : bus1.evt_valid;
        while (v !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
            v = (which == 0) ? bus0.evt_valid : bus1.evt_valid;
        end
        check({tag, " valid"}, 32'(v), 32'd1);
        if (which == 0) check(tag, 32'(bus0.evt_data), 32'(exp));
        else            check(tag, 32'(bus1.evt_data), 32'(exp));
        if (which == 0) bus0.evt_ready = 1'b1;
        else            bus1.evt_ready = 1'b1;
        @(negedge clk);
        bus0.evt_ready = 1'b0;
        bus1.evt_ready = 1'b0;
    endtask

    task automatic pop_both(input string tag, input logic [9:0] exp);
        pop_ev(0, tag, exp);
        pop_ev(1, {tag, " r1"}, exp);
    endtask

    task automatic query(input logic [8:0] code);
        query_code = code;
        repeat (2) @(negedge clk);
    endtask

    int base;
    logic [7:0] keys [9];
    logic [7:0] pause_seq [8];

    initial begin
        bus0.evt_ready = 1'b0;
        bus1.evt_ready = 1'b0;
        keys = '{KEY_A, KEY_S, KEY_D, KEY_SPACE, KEY_W, KEY_UP, KEY_LEFT, KEY_DOWN, KEY_RIGHT};
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        // Reset state
        repeat (4) @(negedge clk);
        check("rst evt_valid", 32'(bus0.evt_valid), 0);
        check("rst evt_count", 32'(bus0.evt_count), 0);
        check("rst evt_data", 32'(bus0.evt_data), 0);
        check("rst any_held", 32'(ah0), 0);
        check("rst query_held", 32'(qh0), 0);
        check("rst frame_err", 32'(fe0), 0);
        check("rst fifo_ovf", 32'(ov0), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Make / break of A
        send_byte(KEY_A);
        check("make A count", 32'(bus0.evt_count), 1);
        query(9'h01C);
        check("A held", 32'(qh0), 1);
        check("A any_held", 32'(ah0), 1);
        pop_both("make A", 10'h21C);
        send_byte(PS2_BRK);
        send_byte(KEY_A);
        pop_both("break A", 10'h01C);
        query(9'h01C);
        check("A released", 32'(qh0), 0);
        check("A any_held off", 32'(ah0), 0);

        // Up arrow held together with W
        send_byte(PS2_EXT);
        send_byte(KEY_UP);
        send_byte(KEY_W);
        pop_both("make up", 10'h375);
        pop_both("make W", 10'h21D);
        query(9'h175);
        check("up held", 32'(qh0), 1);
        query(9'h01D);
        check("W held", 32'(qh0), 1);
        check("two any_held", 32'(ah0), 1);
        send_byte(PS2_EXT);
        send_byte(PS2_BRK);
        send_byte(KEY_UP);
        pop_both("break up", 10'h175);
        check("W still any_held", 32'(ah0), 1);
        send_byte(PS2_BRK);
        send_byte(KEY_W);
        pop_both("break W", 10'h01D);
        repeat (2) @(negedge clk);
        check("none any_held", 32'(ah0), 0);

        // Bad parity frame
        base = ferr0;
        send_byte(KEY_SPACE, 1'b1);
        check("parity err pulses", 32'(ferr0 - base), 1);
        check("parity no event", 32'(bus0.evt_count), 0);
        send_byte(KEY_SPACE);
        pop_both("space after err", 10'h229);
        send_byte(PS2_BRK);
        send_byte(KEY_SPACE);
        pop_both("break space", 10'h029);

        // Watchdog: E0 then a frame that stops after 5 bits
        send_byte(PS2_EXT);
        base = ferr0;
        send_bits(frame_bits(KEY_A, 1'b0), 5);
        repeat (300) @(negedge clk);
        check("timeout not early", 32'(ferr0 - base), 0);
        repeat (100) @(negedge clk);
        check("timeout err", 32'(ferr0 - base), 1);
        check("timeout no event", 32'(bus0.evt_count), 0);
        send_byte(KEY_A);
        pop_both("A after timeout", 10'h21C);
        send_byte(PS2_BRK);
        send_byte(KEY_A);
        pop_both("break A 2", 10'h01C);

        // Overflow: 9 makes into an 8-deep FIFO with no consumer
        base = ovf0;
        for (int i = 0; i < 9; i++) send_byte(keys[i]);
        check("ovf count", 32'(bus0.evt_count), 8);
        check("ovf count r1", 32'(bus1.evt_count), 8);
        check("ovf pulses", 32'(ovf0 - base), 1);
        check("ovf pulses r1", 32'(ovf1), 1);
        for (int i = 0; i < 8; i++) pop_both("drain", {2'b10, keys[i]});
        check("drained", 32'(bus0.evt_count), 0);
        query(9'h074);
        check("dropped key held", 32'(qh0), 1);
        query(9'h01C);
        check("first key held", 32'(qh0), 1);
        check("first key held r1", 32'(qh1), 1);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset clears any_held", 32'(ah0), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Typematic repeat
        for (int i = 0; i < 3; i++) send_byte(KEY_A);
        check("repeat count r0", 32'(bus0.evt_count), 1);
        check("repeat count r1", 32'(bus1.evt_count), 3);
        pop_ev(0, "repeat r0", 10'h21C);
        for (int i = 0; i < 3; i++) pop_ev(1, "repeat r1", 10'h21C);
        check("repeat r0 empty", 32'(bus0.evt_valid), 0);
        send_byte(PS2_BRK);
        send_byte(KEY_A);
        pop_both("break A 3", 10'h01C);

        // Short glitch on ps2_clk while data is low must not start a frame
        base = ferr0;
        ps2_data = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        send_byte(KEY_W);
        pop_both("W after glitch", 10'h21D);
        send_byte(PS2_BRK);
        send_byte(KEY_W);
        pop_both("break W after glitch", 10'h01D);
        check("glitch no err", 32'(ferr0 - base), 0);

        // Pause sequence produces nothing; next key decodes normally
        for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
        check("pause no event", 32'(bus0.evt_count), 0);
        send_byte(KEY_SPACE);
        check("after pause count", 32'(bus0.evt_count), 1);
        pop_both("after pause", 10'h229);
        send_byte(PS2_BRK);
        send_byte(KEY_SPACE);
        pop_both("break space 2", 10'h029);

        // Reset in the middle of a frame
        base = ferr0;
        send_bits(frame_bits(KEY_D, 1'b0), 4);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        check("midframe rst no err", 32'(ferr0 - base), 0);
        check("midframe rst no event", 32'(bus0.evt_count), 0);
        check("frame_err total r1", 32'(ferr1), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Parametrised successor to the team's PS/2 keyboard receiver.
- Deglitches the PS/2 line and checks each frame's start, parity and stop bits, with a frame watchdog.
- Decodes E0 (extended) and F0 (break) prefixes into single key events and buffers them in an event FIFO.
- Keeps a held-key bitmap so game logic (tank movement and fire) can query several simultaneously held keys.
- Sits between the PS/2 pins and the game controller; replaces the one-key ascii/press interface.

Parameters:
FILTER_LEN, 8, consecutive equal samples before the filtered ps2_clk/ps2_data change state (2..16).
FIFO_DEPTH, 8, event FIFO entries; power of 2, 2..64.
TIMEOUT_CYCLES, 200000, clk_100mhz cycles without a falling edge mid-frame before the frame is aborted (2 ms).
REPORT_REPEAT, 0, 1 = typematic repeat makes of an already-held key are pushed; 0 = suppressed.

Ports:
clk_100mhz  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock pin
ps2_data  in  1  raw PS/2 data pin
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head
evt_data  out  10  {make, ext, code[7:0]}; make=1 press, 0 release
evt_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
query_code  in  9  {ext, code} to look up
query_held  out  1  held state of query_code, registered, 1-cycle latency
any_held  out  1  at least one key held
frame_err  out  1  1-cycle pulse on discarded frame
fifo_ovf  out  1  1-cycle pulse when an event is dropped because the FIFO is full

Behaviour:
- Reset (async assert, sync deassert inside): all outputs 0; FIFO empty; bitmap cleared; filters preset to 1 (idle bus); receiver in IDLE; prefix flags cleared.
- Input path: 2-FF synchronizer, then FILTER_LEN saturating filter per line. A falling edge of the filtered clock samples the filtered data.
- Receiver FSM, IDLE -> SHIFT -> CHECK -> IDLE:
  - IDLE: falling edge with data=0 (start) -> SHIFT, bit counter=0. Start bit 1 -> stay in IDLE, pulse frame_err.
  - SHIFT: capture 8 data bits LSB first, then parity, then stop, on successive falling edges.
  - CHECK (one cycle after the stop edge): accept only if parity is odd (XOR of data and parity = 1) and stop=1; otherwise pulse frame_err.
- Watchdog: counter resets on every falling edge. Reaching TIMEOUT_CYCLES in SHIFT -> IDLE, pulse frame_err, clear prefix flags.
- Prefix decoder, on each accepted byte:
  - E0 sets ext.
  - F0 sets brk.
  - E1 starts a 7-byte skip counter; the skipped Pause sequence produces no event.
  - Any other byte forms an event {~brk, ext, byte}, then clears both flags.
  - A frame error also clears both flags.
- Bitmap: 512 bits, indexed {ext, code}. A make sets the bit; a break clears it.
  - Make whose bit is already set: pushed only if REPORT_REPEAT=1; the bitmap is unchanged either way.
  - Break whose bit is already clear: still pushed.
- any_held = OR of the bitmap, registered.
- FIFO: push on event formation, pop when evt_valid && evt_ready; first-word fall-through, evt_data stable while valid and not popped.
  - Full with no pop in the same cycle: drop the event and pulse fifo_ovf; the bitmap update still applies.
  - Full with pop in the same cycle: push succeeds.
  - Empty: pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH; evt_count is exact.
- Latency: event pushed 2 cycles after the stop-bit falling edge; visible on evt_valid the next cycle.
- Reset mid-frame: partial frame is discarded, no event and no frame_err.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PAUSE_SKIP=7;
  - the event struct width (10) and field offsets;
  - named scan codes used by the game: W 1D, A 1C, S 1B, D 23, SPACE 29, and the arrows E0 75/6B/72/74.
- One natural sub-module, ps2_frame_rx: synchronizer, filter, receiver FSM and watchdog; outputs byte_valid, byte, frame_err.
- Prefix decode, bitmap and FIFO stay in the top module.

Test Plan:
- Frame 1C, correct parity, then F0 1C -> evt_data 0x21C then 0x01C; query 0x01C held 1 between the events, 0 after.
- E0 75 (up arrow) held while 1D pressed -> events 0x375, 0x21D; query 0x175 and 0x01D both read 1; any_held=1; release both -> any_held=0.
- Byte 0x29 sent with even parity -> frame_err single pulse, no event; next good 0x29 -> event 0x229.
- Clock stops after 5 bits -> frame_err at TIMEOUT_CYCLES; following good frame decodes; an E0 pending before the timeout is not applied.
- evt_ready=0, 9 makes with FIFO_DEPTH=8 -> evt_count=8, one fifo_ovf pulse; drain returns the first 8 in order; bitmap holds all 9.
- Repeated make 1C x3 with REPORT_REPEAT=0 -> one event; with REPORT_REPEAT=1 -> three events; glitch shorter than FILTER_LEN on ps2_clk -> no bit captured.
